mrt_wr_arb_fifo: RTL and testbench

Parametrised multi-render-target write arbiter for the ROP back end. It sits between the per-RT blend units and the single colour-cache write port. Each RT feeds a small per-RT FIFO with its own valid/ready handshake, and a round-robin arbiter drains the FIFOs into a registered, backpressure-safe memory request stage that can issue one write per cycle. Writes that are disabled or fully byte-masked are accepted from the blend unit and then discarded, so they never reach memory.

---
 rtl/mrt_pkg.sv | 24 ++
 rtl/mrt_rt_fifo.sv | 62 ++++++
 rtl/mrt_wr_arb_fifo.sv | 168 ++++++++++++++++
 tb/tb_mrt_wr_arb_fifo.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrt_pkg.sv
// Shared definitions for the multi-render-target write path: RT limits,
// RT-index width helper and the write record exchanged with the blend units.
package mrt_pkg;

    // Largest number of render targets the back end supports.
    localparam int MRT_MAX_RT     = 8;

    // Default write geometry used by the shared record type.
    localparam int MRT_DEF_DATA_W = 128;
    localparam int MRT_DEF_ADDR_W = 32;

    // Width of an RT index; at least one bit so a two-RT build still has an id.
    function automatic int mrt_id_width(input int num_rt);
        return (num_rt <= 2) ? 1 : $clog2(num_rt);
    endfunction

    // One colour write as produced by a blend unit.
    typedef struct packed {
        logic [MRT_DEF_ADDR_W-1:0]   addr;
        logic [MRT_DEF_DATA_W/8-1:0] be;
        logic [MRT_DEF_DATA_W-1:0]   data;
    } mrt_wr_t;

endpackage

// File: rtl/mrt_rt_fifo.sv
// Per-RT write queue: a small synchronous FIFO with an occupancy count.
// The head entry is always visible on rdata_o; the consumer never pops an
// empty queue and the producer never pushes a full one.
module mrt_rt_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Storage array: written only, never reset, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mrt_wr_arb_fifo.sv
// Multi-render-target write arbiter. Each RT pushes into its own FIFO;
// a round-robin arbiter drains the non-empty FIFOs into a single registered
// memory request stage that can issue one write per cycle. Disabled or fully
// byte-masked writes are accepted and silently discarded.
module mrt_wr_arb_fifo
    import mrt_pkg::*;
#(
    parameter  int NUM_RT     = 4,
    parameter  int DATA_WIDTH = 128,
    parameter  int ADDR_WIDTH = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int RT_ID_W    = mrt_id_width(NUM_RT)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_RT-1:0]            in_valid,
    output logic [NUM_RT-1:0]            in_ready,
    input  logic [NUM_RT*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_RT*ADDR_WIDTH-1:0] in_addr,
    input  logic [NUM_RT*BE_WIDTH-1:0]   in_be,
    input  logic [NUM_RT-1:0]            rt_enable,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [DATA_WIDTH-1:0]        mem_data,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [BE_WIDTH-1:0]          mem_be,
    output logic [RT_ID_W-1:0]           mem_rt_id,
    output logic                         busy
);

    localparam int ENT_W = ADDR_WIDTH + BE_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [RT_ID_W-1:0] LAST_ID = RT_ID_W'(NUM_RT - 1);

    // Elaboration-time guard on the supported parameter space.
    if (NUM_RT < 2 || NUM_RT > MRT_MAX_RT || (DATA_WIDTH % 8) != 0 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("mrt_wr_arb_fifo: unsupported parameter combination");
    end

    logic [NUM_RT-1:0]  push;
    logic [NUM_RT-1:0]  pop;
    logic [NUM_RT-1:0]  nonempty;
    logic [CNT_W-1:0]   fifo_count [NUM_RT];
    logic [ENT_W-1:0]   fifo_head  [NUM_RT];

    logic               any_nonempty;
    logic               load;
    logic [NUM_RT-1:0]  upper_req;
    logic [NUM_RT-1:0]  pick_req;
    logic [RT_ID_W-1:0] grant_id;
    logic [ENT_W-1:0]   grant_head;

    logic               mem_valid_q;
    logic               mem_valid_d;
    logic [ENT_W-1:0]   mem_ent_q;
    logic [ENT_W-1:0]   mem_ent_d;
    logic [RT_ID_W-1:0] mem_rt_id_q;
    logic [RT_ID_W-1:0] mem_rt_id_d;
    logic [RT_ID_W-1:0] ptr_q;
    logic [RT_ID_W-1:0] ptr_d;

    // Per-RT input handshake, drop filter and queue.
    for (genvar gi = 0; gi < NUM_RT; gi++) begin : g_rt
        logic [BE_WIDTH-1:0] be_in;
        logic [ENT_W-1:0]    wr_ent;

        assign be_in  = in_be[gi*BE_WIDTH +: BE_WIDTH];
        assign wr_ent = {in_addr[gi*ADDR_WIDTH +: ADDR_WIDTH], be_in,
                         in_data[gi*DATA_WIDTH +: DATA_WIDTH]};

        // Ready depends on the registered count only, so a full FIFO stays
        // not-ready in the cycle it is popped.
        assign in_ready[gi] = (fifo_count[gi] != CNT_W'(FIFO_DEPTH)) && rstn;

        // Disabled RTs and all-zero byte masks are acknowledged but not stored.
        assign push[gi]     = in_valid[gi] && in_ready[gi] && rt_enable[gi] && (|be_in);
        assign nonempty[gi] = (fifo_count[gi] != '0);
        assign pop[gi]      = load && (grant_id == RT_ID_W'(gi));

        mrt_rt_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENT_W)
        ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .push_i  (push[gi]),
            .pop_i   (pop[gi]),
            .wdata_i (wr_ent),
            .rdata_o (fifo_head[gi]),
            .count_o (fifo_count[gi])
        );
    end

    assign any_nonempty = |nonempty;
    assign load         = (!mem_valid_q || mem_ready) && any_nonempty;

    // Requesters at or above the rotating pointer take precedence.
    always_comb begin
        upper_req = '0;
        for (int i = 0; i < NUM_RT; i++) begin
            upper_req[i] = nonempty[i] && (i >= int'(ptr_q));
        end
    end

    // Lowest-index requester in the preferred set wins; fall back to the
    // full set to wrap past the last RT (valid for any NUM_RT).
    always_comb begin
        pick_req = (|upper_req) ? upper_req : nonempty;
        grant_id = '0;
        for (int i = NUM_RT - 1; i >= 0; i--) begin
            if (pick_req[i]) begin
                grant_id = RT_ID_W'(i);
            end
        end
    end

    // Select the winner's head entry.
    always_comb begin
        grant_head = '0;
        for (int i = 0; i < NUM_RT; i++) begin
            if (grant_id == RT_ID_W'(i)) begin
                grant_head = fifo_head[i];
            end
        end
    end

    // Output stage next-state: load a new grant, retire an accepted request,
    // or hold everything while the memory stalls.
    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_ent_d   = mem_ent_q;
        mem_rt_id_d = mem_rt_id_q;
        ptr_d       = ptr_q;
        if (load) begin
            mem_valid_d = 1'b1;
            mem_ent_d   = grant_head;
            mem_rt_id_d = grant_id;
            ptr_d       = (grant_id == LAST_ID) ? '0 : grant_id + RT_ID_W'(1);
        end else if (mem_valid_q && mem_ready) begin
            mem_valid_d = 1'b0;
        end
    end

    // Output and arbitration registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_valid_q <= 1'b0;
            mem_ent_q   <= '0;
            mem_rt_id_q <= '0;
            ptr_q       <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_ent_q   <= mem_ent_d;
            mem_rt_id_q <= mem_rt_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_ent_q[ENT_W-1 -: ADDR_WIDTH];
    assign mem_be    = mem_ent_q[DATA_WIDTH +: BE_WIDTH];
    assign mem_data  = mem_ent_q[DATA_WIDTH-1:0];
    assign mem_rt_id = mem_rt_id_q;
    assign busy      = any_nonempty || mem_valid_q;

endmodule

// File: tb/tb_mrt_wr_arb_fifo.sv
// Bench for mrt_wr_arb_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference of the arbiter.
// A second, three-RT instance exercises non-power-of-two wrap.
module tb_mrt_wr_arb_fifo;

    localparam int N   = 4;
    localparam int DW  = 128;
    localparam int AW  = 32;
    localparam int D   = 4;
    localparam int BW  = DW / 8;
    localparam int IDW = 2;

    localparam int N3  = 3;
    localparam int DW3 = 16;
    localparam int AW3 = 8;
    localparam int BW3 = DW3 / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N*DW-1:0]   in_data;
    logic [N*AW-1:0]   in_addr;
    logic [N*BW-1:0]   in_be;
    logic [N-1:0]      rt_enable;
    logic              mem_valid;
    logic              mem_ready;
    logic [DW-1:0]     mem_data;
    logic [AW-1:0]     mem_addr;
    logic [BW-1:0]     mem_be;
    logic [IDW-1:0]    mem_rt_id;
    logic              busy;

    logic [N3-1:0]     in_valid3;
    logic [N3-1:0]     in_ready3;
    logic [N3*DW3-1:0] in_data3;
    logic [N3*AW3-1:0] in_addr3;
    logic [N3*BW3-1:0] in_be3;
    logic [N3-1:0]     rt_enable3;
    logic              mem_valid3;
    logic              mem_ready3;
    logic [DW3-1:0]    mem_data3;
    logic [AW3-1:0]    mem_addr3;
    logic [BW3-1:0]    mem_be3;
    logic [1:0]        mem_rt_id3;
    logic              busy3;

    mrt_wr_arb_fifo #(
        .NUM_RT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)
    ) u_dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_be(in_be),
        .rt_enable(rt_enable),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_rt_id(mem_rt_id), .busy(busy)
    );

    mrt_wr_arb_fifo #(
        .NUM_RT(N3), .DATA_WIDTH(DW3), .ADDR_WIDTH(AW3), .FIFO_DEPTH(D)
    ) u_dut3 (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_addr(in_addr3), .in_be(in_be3),
        .rt_enable(rt_enable3),
        .mem_valid(mem_valid3), .mem_ready(mem_ready3),
        .mem_data(mem_data3), .mem_addr(mem_addr3), .mem_be(mem_be3),
        .mem_rt_id(mem_rt_id3), .busy(busy3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_xfer = 0;
    int acc_cnt [N];

    // Reference state: queued writes per RT, the pending memory request and
    // the round-robin start position.
    ent_t mq [N][$];
    ent_t m_out;
    int   m_id;
    bit   m_valid;
    int   m_ptr;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < N; r++) mq[r].delete();
        m_out   = '0;
        m_id    = 0;
        m_valid = 1'b0;
        m_ptr   = 0;
    endtask

    // One clock edge of the reference: grant from queue state before the
    // edge, then enqueue this edge's accepted, non-dropped writes.
    task automatic model_step();
        logic [N-1:0] rdy;
        bit   any;
        int   w;
        ent_t e;
        if (!rstn) begin
            model_reset();
            return;
        end
        any = 1'b0;
        for (int r = 0; r < N; r++) begin
            rdy[r] = (mq[r].size() != D);
            if (mq[r].size() != 0) any = 1'b1;
        end
        if ((!m_valid || mem_ready) && any) begin
            w = m_ptr;
            while (mq[w].size() == 0) w = (w + 1) % N;
            m_out   = mq[w].pop_front();
            m_id    = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % N;
        end else if (m_valid && mem_ready) begin
            m_valid = 1'b0;
        end
        for (int r = 0; r < N; r++) begin
            e.addr = in_addr[r*AW +: AW];
            e.be   = in_be[r*BW +: BW];
            e.data = in_data[r*DW +: DW];
            if (in_valid[r] && rdy[r] && rt_enable[r] && (e.be != '0)) mq[r].push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check_outputs();
        logic [N-1:0] er;
        bit any;
        any = 1'b0;
        for (int r = 0; r < N; r++) begin
            er[r] = rstn && (mq[r].size() != D);
            if (mq[r].size() != 0) any = 1'b1;
        end
        check_eq("in_ready",  in_ready,  er);
        check_eq("busy",      busy,      any || m_valid);
        check_eq("mem_valid", mem_valid, m_valid);
        check_eq("mem_rt_id", mem_rt_id, m_id);
        check_eq("mem_addr",  mem_addr,  m_out.addr);
        check_eq("mem_be",    mem_be,    m_out.be);
        check_eq("mem_data",  mem_data,  m_out.data);
    endtask

    // Called at a falling edge with inputs set: log handshakes, advance one
    // clock, then compare outputs at the next falling edge.
    task automatic cycle();
        for (int r = 0; r < N; r++) if (in_valid[r] && in_ready[r]) acc_cnt[r]++;
        if (mem_valid && mem_ready) begin
            n_xfer++;
            $display("xfer %0d: rt=%0d addr=%h be=%h", n_xfer, mem_rt_id, mem_addr, mem_be);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_ent(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        in_addr[r*AW +: AW] = a;
        in_data[r*DW +: DW] = d;
        in_be[r*BW +: BW]   = b;
    endtask

    task automatic rand_ent(input int r, input bit allow_zero_be);
        logic [BW-1:0] b;
        b = BW'($urandom);
        if (allow_zero_be && ($urandom % 8 == 0)) b = '0;
        else if (b == '0) b = BW'(1);
        set_ent(r, $urandom, {$urandom, $urandom, $urandom, $urandom}, b);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        in_valid  = '0;
        mem_ready = 1'b1;
        while (busy && t < 200) begin
            cycle();
            t++;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, a0, a1, a3, lat, t, k, total;
        int sent [N];
        logic [N-1:0] acc;

        rstn = 1'b0;
        in_valid = '0; in_data = '0; in_addr = '0; in_be = '0;
        rt_enable = '1; mem_ready = 1'b1;
        in_valid3 = '0; in_data3 = '0; in_addr3 = '0; in_be3 = '0;
        rt_enable3 = '1; mem_ready3 = 1'b1;
        for (int r = 0; r < N; r++) acc_cnt[r] = 0;
        model_reset();

        // Reset state
        @(negedge clk);
        repeat (3) cycle();
        check_eq("rst_busy", busy, 1'b0);
        rstn = 1'b1;
        cycle();

        // Single write from RT2
        x0 = n_xfer;
        set_ent(2, 32'h1000, {16{8'hA5}}, '1);
        in_valid = 4'b0100;
        cycle();
        in_valid = '0;
        lat = 0;
        while (!mem_valid && lat < 10) begin
            cycle();
            lat++;
        end
        check_eq("single_latency", lat, 1);
        check_eq("single_rt_id", mem_rt_id, 2);
        check_eq("single_addr", mem_addr, 32'h1000);
        drain("single_drain");
        check_eq("single_count", n_xfer - x0, 1);

        // Full contention: 8 writes from every RT
        x0 = n_xfer;
        for (int r = 0; r < N; r++) sent[r] = 0;
        t = 0;
        total = 0;
        while (total < 8 * N && t < 300) begin
            for (int r = 0; r < N; r++) begin
                in_valid[r] = (sent[r] < 8);
                rand_ent(r, 1'b0);
            end
            acc = in_valid & in_ready;
            cycle();
            total = 0;
            for (int r = 0; r < N; r++) begin
                if (acc[r]) sent[r]++;
                total += sent[r];
            end
            t++;
        end
        check_eq("contention_sent", total, 8 * N);
        drain("contention_drain");
        check_eq("contention_count", n_xfer - x0, 8 * N);

        // Backpressure with RT0 streaming
        x0 = n_xfer;
        a0 = acc_cnt[0];
        mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 4'b0001;
            rand_ent(0, 1'b0);
            cycle();
        end
        check_eq("bp_accepted", acc_cnt[0] - a0, D + 1);
        check_eq("bp_in_ready", in_ready[0], 1'b0);
        check_eq("bp_stalled", n_xfer - x0, 0);
        drain("bp_drain");
        check_eq("bp_count", n_xfer - x0, D + 1);

        // Drops: disabled RT1 and zero byte mask on RT3
        rt_enable = 4'b1101;
        x0 = n_xfer;
        a1 = acc_cnt[1];
        a3 = acc_cnt[3];
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b0010;
            rand_ent(1, 1'b0);
            cycle();
        end
        in_valid = 4'b1000;
        rand_ent(3, 1'b0);
        in_be[3*BW +: BW] = '0;
        cycle();
        in_valid = '0;
        repeat (3) cycle();
        check_eq("drop_acc_rt1", acc_cnt[1] - a1, 3);
        check_eq("drop_acc_rt3", acc_cnt[3] - a3, 1);
        check_eq("drop_count", n_xfer - x0, 0);
        check_eq("drop_busy", busy, 1'b0);
        rt_enable = '1;

        // Odd RT count on the three-RT instance
        mem_ready3 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid3 = '1;
            for (int r = 0; r < N3; r++) begin
                in_data3[r*DW3 +: DW3] = DW3'(c * N3 + r + 1);
                in_addr3[r*AW3 +: AW3] = AW3'(r);
                in_be3[r*BW3 +: BW3]   = '1;
            end
            cycle();
        end
        in_valid3  = '0;
        mem_ready3 = 1'b1;
        k = 0;
        t = 0;
        while (k < 2 * N3 && t < 30) begin
            if (mem_valid3) begin
                check_eq("odd_grant", mem_rt_id3, k % N3);
                check_eq("odd_data", mem_data3, k + 1);
                k++;
            end
            cycle();
            t++;
        end
        check_eq("odd_count", k, 2 * N3);
        check_eq("odd_busy", busy3, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid = N'($urandom);
            for (int r = 0; r < N; r++) rand_ent(r, 1'b1);
            mem_ready = ($urandom % 4) != 0;
            if ($urandom % 50 == 0) rt_enable = N'($urandom);
            cycle();
        end
        rt_enable = '1;
        drain("rand_drain");

        // Mid-burst reset
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = '1;
            for (int r = 0; r < N; r++) rand_ent(r, 1'b0);
            cycle();
        end
        in_valid = '0;
        check_eq("prerst_valid", mem_valid, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_async_valid", mem_valid, 1'b0);
        check_eq("rst_async_ready", in_ready, '0);
        check_eq("rst_async_busy", busy, 1'b0);
        check_eq("rst_async_data", mem_data, '0);
        model_reset();
        repeat (2) cycle();
        rstn = 1'b1;
        mem_ready = 1'b1;
        in_valid = '1;
        for (int r = 0; r < N; r++) rand_ent(r, 1'b0);
        cycle();
        in_valid = '0;
        t = 0;
        while (!mem_valid && t < 10) begin
            cycle();
            t++;
        end
        check_eq("rst_first_valid", mem_valid, 1'b1);
        check_eq("rst_first_grant", mem_rt_id, 0);
        drain("rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
